// File: rtl/chan_fifo_writer.sv
// chan_fifo_writer: packs strobed RX I/Q samples into framed channel packets
// (header, timestamp, payload) and writes them into the per-channel RX FIFO.
module chan_fifo_writer #(
    parameter int          SPACE_W  = 9,
    parameter logic [31:0] PAD_WORD = 32'h0
) (
    input  logic               rx_clock,
    input  logic               reset,
    input  logic               rx_strobe,
    input  logic [15:0]        rx_i,
    input  logic [15:0]        rx_q,
    input  logic               rx_enable,
    input  logic [31:0]        timestamp_clock,
    input  logic [6:0]         pkt_len,
    input  logic [SPACE_W-1:0] fifo_space,
    input  logic [31:0]        rssi,
    input  logic [31:0]        threshhold,
    output logic               wrreq,
    output logic [31:0]        fifodata,
    output logic               overrun,
    output logic               burst,
    output logic [14:0]        debug
);
    typedef enum logic [3:0] {
        IDLE, ARMED, HEADER, TIMESTAMP, FIRST, PAYLOAD, PAD, EOB_HDR, EOB_TS
    } state_t;

    state_t      r_state;
    logic [6:0]  r_len;
    logic [6:0]  r_cnt;
    logic        r_sob;
    logic [31:0] r_sample;
    logic [31:0] r_ts;
    logic        w_room;
    logic        w_eob_room;
    logic        w_rssi;
    logic [31:0] w_hdr;
    logic [31:0] w_eob_hdr;

    // A packet starts only if the whole packet fits, so padding never needs to check space.
    assign w_room     = 32'(fifo_space) >= 32'(r_len) + 32'd2;
    assign w_eob_room = 32'(fifo_space) >= 32'd2;
    assign w_rssi     = rssi > threshhold;
    assign w_hdr      = {3'b0, r_sob, 1'b0, w_rssi, 1'b0, 16'b0, r_len, 2'b0};
    assign w_eob_hdr  = {3'b0, r_sob, 1'b1, 27'b0};
    assign debug      = {8'd0, wrreq, overrun, burst, r_state[2:0], rx_strobe};

    // Outputs are registered on entry to each state, so a word is on the bus while its state is current.
    always_ff @(posedge rx_clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_sob    <= 1'b0;
            r_sample <= '0;
            r_ts     <= '0;
            wrreq    <= 1'b0;
            fifodata <= '0;
            overrun  <= 1'b0;
            burst    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    wrreq <= 1'b0;
                    if (rx_enable) begin
                        r_len   <= (pkt_len == 7'd0) ? 7'd1 : pkt_len;
                        r_cnt   <= '0;
                        r_sob   <= 1'b1;
                        burst   <= 1'b1;
                        overrun <= 1'b0;
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    wrreq <= 1'b0;
                    if (!rx_enable) begin
                        r_state <= EOB_HDR;
                    end else if (rx_strobe) begin
                        if (w_room) begin
                            r_sample <= {rx_q, rx_i};
                            r_ts     <= timestamp_clock;
                            wrreq    <= 1'b1;
                            fifodata <= w_hdr;
                            r_state  <= HEADER;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    fifodata <= r_ts;
                    r_sob    <= 1'b0;
                    r_state  <= TIMESTAMP;
                end
                TIMESTAMP: begin
                    fifodata <= r_sample;
                    r_cnt    <= 7'd1;
                    r_state  <= FIRST;
                end
                FIRST: begin
                    wrreq   <= 1'b0;
                    r_state <= (r_cnt == r_len) ? ARMED : PAYLOAD;
                end
                PAYLOAD: begin
                    if (r_cnt == r_len) begin
                        wrreq   <= 1'b0;
                        r_state <= ARMED;
                    end else if (!rx_enable) begin
                        wrreq    <= 1'b1;
                        fifodata <= PAD_WORD;
                        r_cnt    <= r_cnt + 7'd1;
                        r_state  <= PAD;
                    end else if (rx_strobe) begin
                        wrreq    <= 1'b1;
                        fifodata <= {rx_q, rx_i};
                        r_cnt    <= r_cnt + 7'd1;
                    end else begin
                        wrreq <= 1'b0;
                    end
                end
                PAD: begin
                    if (r_cnt == r_len) begin
                        wrreq   <= 1'b0;
                        r_state <= EOB_HDR;
                    end else begin
                        wrreq    <= 1'b1;
                        fifodata <= PAD_WORD;
                        r_cnt    <= r_cnt + 7'd1;
                    end
                end
                EOB_HDR: begin
                    if (wrreq) begin
                        fifodata <= timestamp_clock;
                        r_sob    <= 1'b0;
                        r_state  <= EOB_TS;
                    end else if (w_eob_room) begin
                        wrreq    <= 1'b1;
                        fifodata <= w_eob_hdr;
                    end
                end
                EOB_TS: begin
                    wrreq   <= 1'b0;
                    burst   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    wrreq   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chan_fifo_writer.sv
// tb_chan_fifo_writer: directed scoreboard bench; expected FIFO words are queued
// as stimulus is driven and popped whenever the writer asserts wrreq.
module tb_chan_fifo_writer;
    logic        rx_clock = 1'b0;
    logic        reset;
    logic        rx_strobe;
    logic [15:0] rx_i;
    logic [15:0] rx_q;
    logic        rx_enable;
    logic [31:0] timestamp_clock;
    logic [6:0]  pkt_len;
    logic [8:0]  fifo_space;
    logic [31:0] rssi;
    logic [31:0] threshhold;
    logic        wrreq;
    logic [31:0] fifodata;
    logic        overrun;
    logic        burst;
    logic [14:0] debug;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q[$];

    always #5 rx_clock = ~rx_clock;

    chan_fifo_writer dut (
        .rx_clock(rx_clock), .reset(reset), .rx_strobe(rx_strobe), .rx_i(rx_i), .rx_q(rx_q),
        .rx_enable(rx_enable), .timestamp_clock(timestamp_clock), .pkt_len(pkt_len),
        .fifo_space(fifo_space), .rssi(rssi), .threshhold(threshhold), .wrreq(wrreq),
        .fifodata(fifodata), .overrun(overrun), .burst(burst), .debug(debug)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rx_clock);
        #1;
    endtask

    task automatic samp(input logic [15:0] i, input logic [15:0] qv);
        q.push_back({qv, i});
        rx_i = i;
        rx_q = qv;
        rx_strobe = 1'b1;
        tick(1);
        rx_strobe = 1'b0;
        tick(3);
    endtask

    task automatic end_burst(input logic [31:0] ts, input logic [31:0] hdr);
        timestamp_clock = ts;
        q.push_back(hdr);
        q.push_back(ts);
        rx_enable = 1'b0;
        tick(8);
        chk("burst_off", burst, 1'b0);
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    always @(negedge rx_clock) begin
        if (wrreq === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_write observed=%h expected=none", fifodata);
            end else begin
                chk("fifo_word", fifodata, q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        rx_strobe = 1'b0;
        rx_i = '0;
        rx_q = '0;
        rx_enable = 1'b0;
        timestamp_clock = '0;
        pkt_len = 7'd0;
        fifo_space = 9'd100;
        rssi = '0;
        threshhold = '0;
        tick(3);
        chk("rst_wrreq", wrreq, 1'b0);
        chk("rst_fifodata", fifodata, 32'h0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_burst", burst, 1'b0);
        chk("rst_debug", 32'(debug), 32'h0);
        reset = 1'b0;
        tick(2);

        // basic single packet
        pkt_len = 7'd3;
        rx_enable = 1'b1;
        tick(2);
        chk("burst_on", burst, 1'b1);
        timestamp_clock = 32'd1000;
        q.push_back(32'h1000000C);
        q.push_back(32'd1000);
        samp(16'd1, 16'h10);
        samp(16'd2, 16'h11);
        samp(16'd3, 16'h12);
        end_burst(32'd2000, 32'h08000000);

        // multi-packet burst
        pkt_len = 7'd2;
        rx_enable = 1'b1;
        tick(2);
        timestamp_clock = 32'd3000;
        q.push_back(32'h10000008);
        q.push_back(32'd3000);
        samp(16'h21, 16'h31);
        samp(16'h22, 16'h32);
        timestamp_clock = 32'd3100;
        q.push_back(32'h00000008);
        q.push_back(32'd3100);
        samp(16'h23, 16'h33);
        samp(16'h24, 16'h34);
        end_burst(32'd3200, 32'h08000000);

        // early end with padding
        pkt_len = 7'd4;
        rx_enable = 1'b1;
        tick(2);
        timestamp_clock = 32'd4000;
        q.push_back(32'h10000010);
        q.push_back(32'd4000);
        samp(16'h51, 16'h61);
        samp(16'h52, 16'h62);
        chk("burst_mid", burst, 1'b1);
        q.push_back(32'h0);
        q.push_back(32'h0);
        end_burst(32'd4100, 32'h08000000);
        chk("no_overrun", overrun, 1'b0);

        // overrun then retry
        pkt_len = 7'd10;
        fifo_space = 9'd11;
        rx_enable = 1'b1;
        tick(2);
        rx_i = 16'hDEAD;
        rx_q = 16'hBEEF;
        rx_strobe = 1'b1;
        tick(1);
        rx_strobe = 1'b0;
        tick(3);
        chk("overrun_set", overrun, 1'b1);
        chk("overrun_nowrite", 32'(q.size()), 32'd0);
        fifo_space = 9'd12;
        timestamp_clock = 32'd5000;
        q.push_back(32'h10000028);
        q.push_back(32'd5000);
        for (int k = 0; k < 10; k++) samp(16'(k + 1), 16'(16'h40 + k));
        chk("overrun_sticky", overrun, 1'b1);
        end_burst(32'd5100, 32'h08000000);

        // RSSI tagging, pkt_len 0 treated as 1
        fifo_space = 9'd100;
        pkt_len = 7'd0;
        rssi = 32'd50;
        threshhold = 32'd40;
        rx_enable = 1'b1;
        tick(2);
        chk("overrun_clear", overrun, 1'b0);
        timestamp_clock = 32'd6000;
        q.push_back(32'h14000004);
        q.push_back(32'd6000);
        samp(16'd7, 16'd8);
        rssi = 32'd40;
        timestamp_clock = 32'd6100;
        q.push_back(32'h00000004);
        q.push_back(32'd6100);
        samp(16'd9, 16'd10);
        end_burst(32'd6200, 32'h08000000);

        // empty burst, EOB waits for space
        rx_enable = 1'b1;
        tick(2);
        fifo_space = 9'd1;
        timestamp_clock = 32'd7000;
        rx_enable = 1'b0;
        tick(6);
        chk("eob_wait_burst", burst, 1'b1);
        chk("eob_wait_nowrite", 32'(q.size()), 32'd0);
        q.push_back(32'h18000000);
        q.push_back(32'd7000);
        fifo_space = 9'd100;
        tick(8);
        chk("empty_burst_off", burst, 1'b0);
        chk("empty_drain", 32'(q.size()), 32'd0);

        // async reset mid-payload
        pkt_len = 7'd4;
        rx_enable = 1'b1;
        tick(2);
        timestamp_clock = 32'd8000;
        q.push_back(32'h10000010);
        q.push_back(32'd8000);
        samp(16'h71, 16'h81);
        rx_i = 16'h72;
        rx_q = 16'h82;
        rx_strobe = 1'b1;
        tick(1);
        rx_strobe = 1'b0;
        chk("payload_wrreq", wrreq, 1'b1);
        reset = 1'b1;
        #2;
        chk("arst_wrreq", wrreq, 1'b0);
        chk("arst_burst", burst, 1'b0);
        chk("arst_state", 32'(debug[3:1]), 32'd0);
        chk("arst_fifodata", fifodata, 32'h0);
        rx_enable = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(10);
        chk("post_rst_burst", burst, 1'b0);
        chk("post_rst_drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
